uart_led_cmd_parser: RTL
========================

# uart_led_cmd_parser

Byte-stream command parser between the UART receiver and the board LEDs, driving a parametrised bank of `N_CH` outputs. Frames select one channel (or all), apply any number of ON/OFF/TOGGLE commands and close with a terminator. Output state is held across frames. Unlike the fixed 4-channel parser, it adds a byte-valid qualifier, a broadcast key, an inter-byte timeout and error/frame-done status.

## Interface
Parameters:
- `N_CH`, 4: number of output channels, 1..15.
- `KEY_BASE`, 8'hB0: key for channel 0; channel k uses `KEY_BASE+k`.
- `KEY_ALL`, 8'hBF: broadcast key selecting all channels. Must lie outside `KEY_BASE..KEY_BASE+N_CH-1`.
- `CMD_OFF`, 8'h00 / `CMD_ON`, 8'hFF / `CMD_TOG`, 8'h55 / `CMD_END`, 8'hAA: command bytes. All distinct and outside the key range.
- `TIMEOUT_CYC`, 1000000: idle cycles allowed inside a frame; 0 disables the timeout. Counter width is `$clog2(TIMEOUT_CYC+1)`.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `data`, in, 8: received byte, qualified by `data_valid`.
- `data_valid`, in, 1: one-cycle strobe per received byte. Bytes without the strobe are ignored.
- `out`, out, `N_CH`: registered LED drive.
- `busy`, out, 1: high while in state CMD.
- `frame_done`, out, 1: one-cycle pulse when `CMD_END` closes a frame.
- `err`, out, 1: one-cycle pulse on a protocol error or timeout.

## Operation
- Reset: `out`=0, state=IDLE, select mask=0, timeout counter=0, `busy`=0, `frame_done`=0, `err`=0. A reset in the middle of a frame aborts the frame and clears `out`.
- Select mask: an `N_CH`-bit register. Channel key k loads one-hot bit k; `KEY_ALL` loads all ones.
- IDLE, on a valid byte:
  - Channel key or `KEY_ALL`: load the mask, go to CMD, clear the counter.
  - Any other byte: pulse `err`, stay in IDLE.
  - `out` is never modified in IDLE.
- CMD, on a valid byte:
  - `CMD_ON`: `out |= mask`.
  - `CMD_OFF`: `out &= ~mask`.
  - `CMD_TOG`: `out ^= mask`.
  - `CMD_END`: go to IDLE, pulse `frame_done`, clear the mask.
  - Channel key or `KEY_ALL`: reload the mask and stay in CMD. This is a re-select; it is not an error.
  - Any other byte: pulse `err`, stay in CMD; mask and `out` are unchanged.
  - Every valid byte clears the timeout counter.
- Timeout (only when `TIMEOUT_CYC` > 0):
  - In CMD, each cycle without `data_valid` increments the counter.
  - If the counter equals `TIMEOUT_CYC-1` and `data_valid` is low, the next edge sets state=IDLE, pulses `err`, clears the mask and clears the counter.
  - `out` keeps its value on timeout.
- Channels outside the mask are never altered.
- `frame_done` and `err` are never asserted in the same cycle.

## Timing
- Latency: a valid byte sampled at edge n updates `out`, state, `busy`, `frame_done` and `err` at edge n (visible in cycle n+1). There are no combinational paths from `data` to any output.
- Back-to-back throughput: one byte per clock. Consecutive `data_valid` cycles are all processed.
- Timeout fires on the `TIMEOUT_CYC`-th consecutive idle cycle in CMD. A valid byte arriving in that same cycle wins: it is processed normally and the counter is cleared.
- `reset` has priority over `data_valid` in the same cycle; that byte is discarded.
- Pulses last exactly one cycle, even when errors occur back to back (each bad byte gives its own pulse).

## Test plan
- Reset, then bytes B1,FF,AA with `data_valid` → `out`=4'b0010 one cycle after FF. `frame_done` pulses once after AA. `busy` is high from B1 through AA.
- Bytes B0,FF,AA then B3,FF,AA → `out`=4'b1001; the earlier channel is held across frames.
- Bytes BF,FF,55,B2,00,AA → `out` goes 4'b1111, then 4'b0000, then 4'b0000 (the 00 re-clears only channel 2); no `err`.
- Byte 12 in IDLE → `err` pulse, `out` unchanged. Then B0,37 → `err` pulse, still CMD. Then FF → `out[0]`=1.
- With `TIMEOUT_CYC`=8: send B2, then 8 idle cycles → `err` pulse, `busy`=0. A following FF is ignored and flagged as an IDLE error. Repeat with FF arriving on the 8th idle cycle → FF is applied, no timeout.
- Bytes B0,FF then `reset` in the middle of the frame, coinciding with an AA strobe → `out`=0, `busy`=0, no `frame_done`.

Source files
------------

// File: rtl/uart_led_cmd_parser.sv
// Byte-stream LED command parser: key selects channel(s), ON/OFF/TOGGLE commands
// apply to the selection, END closes the frame. Includes inter-byte timeout and status pulses.
module uart_led_cmd_parser #(
   parameter int         N_CH        = 4,
   parameter logic [7:0] KEY_BASE    = 8'hB0,
   parameter logic [7:0] KEY_ALL     = 8'hBF,
   parameter logic [7:0] CMD_OFF     = 8'h00,
   parameter logic [7:0] CMD_ON      = 8'hFF,
   parameter logic [7:0] CMD_TOG     = 8'h55,
   parameter logic [7:0] CMD_END     = 8'hAA,
   parameter int         TIMEOUT_CYC = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      data,
   input  logic            data_valid,
   output logic [N_CH-1:0] out,
   output logic            busy,
   output logic            frame_done,
   output logic            err
);

   // A width of at least one keeps the counter legal when the timeout is disabled.
   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic {IDLE, CMD} state_t;

   state_t          state_reg, state_next;
   logic [N_CH-1:0] mask_reg, mask_next;
   logic [N_CH-1:0] out_reg, out_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic            frame_done_reg, frame_done_next;
   logic            err_reg, err_next;

   logic [N_CH-1:0] key_hit;
   logic            is_all;
   logic            is_sel;
   logic [N_CH-1:0] sel_mask;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_key
         localparam logic [7:0] KEY_GI = KEY_BASE + 8'(gi);
         assign key_hit[gi] = (data == KEY_GI);
      end
   endgenerate

   assign is_all   = (data == KEY_ALL);
   assign is_sel   = is_all | (|key_hit);
   assign sel_mask = is_all ? {N_CH{1'b1}} : key_hit;

   always_comb begin
      state_next      = state_reg;
      mask_next       = mask_reg;
      out_next        = out_reg;
      cnt_next        = cnt_reg;
      frame_done_next = 1'b0;
      err_next        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (data_valid) begin
               if (is_sel) begin
                  mask_next  = sel_mask;
                  state_next = CMD;
                  cnt_next   = '0;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         CMD: begin
            if (data_valid) begin
               cnt_next = '0;
               if (is_sel) begin
                  mask_next = sel_mask;
               end else if (data == CMD_ON) begin
                  out_next = out_reg | mask_reg;
               end else if (data == CMD_OFF) begin
                  out_next = out_reg & ~mask_reg;
               end else if (data == CMD_TOG) begin
                  out_next = out_reg ^ mask_reg;
               end else if (data == CMD_END) begin
                  state_next      = IDLE;
                  frame_done_next = 1'b1;
                  mask_next       = '0;
               end else begin
                  err_next = 1'b1;
               end
            end else if (TIMEOUT_CYC > 0) begin
               // A byte in the final idle cycle takes the branch above and wins.
               if (cnt_reg == CNT_LAST) begin
                  state_next = IDLE;
                  err_next   = 1'b1;
                  mask_next  = '0;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         mask_reg       <= '0;
         out_reg        <= '0;
         cnt_reg        <= '0;
         frame_done_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mask_reg       <= mask_next;
         out_reg        <= out_next;
         cnt_reg        <= cnt_next;
         frame_done_reg <= frame_done_next;
         err_reg        <= err_next;
      end
   end

   assign out        = out_reg;
   assign busy       = (state_reg == CMD);
   assign frame_done = frame_done_reg;
   assign err        = err_reg;

endmodule
